accel_mailbox: RTL and testbench

- Accelerator-side bridge on the CPU's accel_*/cpu_* ports, sitting directly downstream of the CPU top level.
- Watches CPU stores for a doorbell write, fetches the 512-bit message block from CPU data memory over the accel read port, and hands it to the hash accelerator with a valid/ready handshake.
- Accepts the 256-bit digest back and writes it into CPU data memory as eight 32-bit words.

---
 rtl/accel_mailbox_pkg.sv | 31 +++
 rtl/accel_mailbox_if.sv | 43 ++++
 rtl/accel_mailbox_wb.sv | 58 +++++
 rtl/accel_mailbox.sv | 119 +++++++++++
 tb/tb_accel_mailbox.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accel_mailbox_pkg
// Brief   : Shared types and constants for the accelerator mailbox bridge.
// Revision: 1.0 - initial release
// ============================================================================
package accel_mailbox_pkg;

    localparam logic [15:0] DEFAULT_DOORBELL_ADDR = 16'hFFF0;

    // Field positions inside the doorbell store data
    localparam int SRC_LSB  = 0;
    localparam int DST_LSB  = 16;

    localparam int ADDR_W   = 16;
    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_CAP   = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_DIG = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6
    } mb_state_t;

endpackage
`default_nettype wire

// File: rtl/accel_mailbox_if.sv
`default_nettype none
// ============================================================================
// Module  : accel_mailbox_if
// Brief   : CPU store snoop, data-memory port and accelerator handshakes.
//           master = CPU/memory/accelerator side, slave = mailbox.
// Revision: 1.0 - initial release
// ============================================================================
interface accel_mailbox_if;
    import accel_mailbox_pkg::*;

    logic                cpu_wrt_en;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [WORD_W-1:0]   cpu_wrt_data;
    logic [BLOCK_W-1:0]  accel_rd_data;
    logic [ADDR_W-1:0]   accel_addr;
    logic                accel_wrt_en;
    logic [WORD_W-1:0]   accel_wrt_data;
    logic                blk_valid;
    logic                blk_ready;
    logic [BLOCK_W-1:0]  blk_data;
    logic                dig_valid;
    logic                dig_ready;
    logic [DIGEST_W-1:0] dig_data;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output cpu_wrt_en, cpu_addr, cpu_wrt_data, accel_rd_data,
               blk_ready, dig_valid, dig_data,
        input  accel_addr, accel_wrt_en, accel_wrt_data, blk_valid,
               blk_data, dig_ready, busy, done, err
    );

    modport slave (
        input  cpu_wrt_en, cpu_addr, cpu_wrt_data, accel_rd_data,
               blk_ready, dig_valid, dig_data,
        output accel_addr, accel_wrt_en, accel_wrt_data, blk_valid,
               blk_data, dig_ready, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/accel_mailbox_wb.sv
`default_nettype none
// ============================================================================
// Module  : accel_mailbox_wb
// Brief   : Digest write-back serialiser: holds the digest, steps a word
//           index, and produces the address/word for each write.
// Revision: 1.0 - initial release
// ============================================================================
module accel_mailbox_wb
    import accel_mailbox_pkg::*;
#(
    parameter int RESULT_WORDS = 8,
    parameter int ADDR_STRIDE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,   // load digest, restart at word 0
    input  logic                i_adv,     // current word is being written
    input  logic [DIGEST_W-1:0] i_digest,
    input  logic [ADDR_W-1:0]   i_base,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [WORD_W-1:0]   o_data,
    output logic                o_last
);

    localparam int IDX_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;

    logic [IDX_W-1:0]    r_idx;
    logic [DIGEST_W-1:0] r_dig;

    // Digest capture and word index; index parks on the last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_dig <= '0;
        end else if (i_start) begin
            r_idx <= '0;
            r_dig <= i_digest;
        end else if (i_adv && !o_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Word select: word 0 is the most significant (H0) word
    always_comb begin
        o_data = '0;
        for (int k = 0; k < RESULT_WORDS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                o_data = r_dig[DIGEST_W-1-WORD_W*k -: WORD_W];
            end
        end
    end

    // Address arithmetic is deliberately ADDR_W wide so it wraps
    assign o_addr = i_base + ADDR_W'(ADDR_STRIDE) * ADDR_W'(r_idx);
    assign o_last = (r_idx == IDX_W'(RESULT_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/accel_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : accel_mailbox
// Brief   : Doorbell-triggered bridge: fetches a 512-bit block from CPU data
//           memory, hands it to the hash accelerator and writes the 256-bit
//           digest back as 32-bit words.
// Revision: 1.0 - initial release
// ============================================================================
module accel_mailbox
    import accel_mailbox_pkg::*;
#(
    parameter logic [15:0] DOORBELL_ADDR = DEFAULT_DOORBELL_ADDR,
    parameter int          RESULT_WORDS  = 8,
    parameter int          ADDR_STRIDE   = 4
) (
    input  logic           clk,
    input  logic           rst,
    accel_mailbox_if.slave bus
);

    mb_state_t          r_state;
    mb_state_t          w_next;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  r_dst;
    logic [BLOCK_W-1:0] r_blk;
    logic               r_err;

    logic               w_doorbell;
    logic               w_db_accept;
    logic               w_dig_take;
    logic [ADDR_W-1:0]  w_wb_addr;
    logic [WORD_W-1:0]  w_wb_data;
    logic               w_wb_last;

    assign w_doorbell  = bus.cpu_wrt_en && (bus.cpu_addr == DOORBELL_ADDR);
    assign w_db_accept = w_doorbell && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dig_take  = (r_state == S_WAIT_DIG) && bus.dig_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_db_accept) w_next = S_RD_REQ;
            S_RD_REQ:   w_next = S_RD_CAP;
            S_RD_CAP:   w_next = S_SEND;
            S_SEND:     if (bus.blk_ready) w_next = S_WAIT_DIG;
            S_WAIT_DIG: if (bus.dig_valid) w_next = S_WRITE;
            S_WRITE:    if (w_wb_last) w_next = S_DONE;
            S_DONE:     w_next = w_db_accept ? S_RD_REQ : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Job parameters, captured block and sticky busy-doorbell error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src <= '0;
            r_dst <= '0;
            r_blk <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_db_accept) begin
                r_src <= bus.cpu_wrt_data[SRC_LSB +: ADDR_W];
                r_dst <= bus.cpu_wrt_data[DST_LSB +: ADDR_W];
                r_err <= 1'b0;
            end else if (w_doorbell) begin
                r_err <= 1'b1;
            end
            if (r_state == S_RD_CAP) begin
                r_blk <= bus.accel_rd_data;
            end
        end
    end

    accel_mailbox_wb #(
        .RESULT_WORDS (RESULT_WORDS),
        .ADDR_STRIDE  (ADDR_STRIDE)
    ) u_wb (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_dig_take),
        .i_adv    (r_state == S_WRITE),
        .i_digest (bus.dig_data),
        .i_base   (r_dst),
        .o_addr   (w_wb_addr),
        .o_data   (w_wb_data),
        .o_last   (w_wb_last)
    );

    // Outputs are decoded from state so an async reset clears them at once
    always_comb begin
        bus.accel_addr = '0;
        if ((r_state == S_RD_REQ) || (r_state == S_RD_CAP)) begin
            bus.accel_addr = r_src;
        end else if (r_state == S_WRITE) begin
            bus.accel_addr = w_wb_addr;
        end
    end

    assign bus.accel_wrt_en   = (r_state == S_WRITE);
    assign bus.accel_wrt_data = (r_state == S_WRITE) ? w_wb_data : '0;
    assign bus.blk_valid      = (r_state == S_SEND);
    assign bus.blk_data       = r_blk;
    assign bus.dig_ready      = (r_state == S_WAIT_DIG);
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_accel_mailbox.sv
`default_nettype none
// ============================================================================
// Module  : tb_accel_mailbox
// Brief   : Scoreboard bench for accel_mailbox. Stimulus pushes expected
//           blocks, writes and done times; a negedge monitor pops/compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_accel_mailbox;
    import accel_mailbox_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_seen = 0;
    logic [31:0] salt = '0;

    wr_t          exp_wr[$];
    logic [511:0] exp_blk[$];
    int           exp_done[$];

    localparam logic [255:0] D1 = 256'h01234567_89ABCDEF_DEADBEEF_CAFEBABE_11223344_55667788_99AABBCC_0BADCDEF;
    localparam logic [255:0] D2 = 256'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F_AAAA5555_12345678_9ABCDEF0_FFFF0000;
    logic [31:0] W1[8] = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'hCAFEBABE,
                           32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0BADCDEF};
    logic [31:0] W2[8] = '{32'hF0E1D2C3, 32'hB4A59687, 32'h78695A4B, 32'h3C2D1E0F,
                           32'hAAAA5555, 32'h12345678, 32'h9ABCDEF0, 32'hFFFF0000};
    logic [15:0] WRAP_A[8] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004,
                               16'h0008, 16'h000C, 16'h0010, 16'h0014};

    accel_mailbox_if bus ();

    accel_mailbox dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] blk_of(input logic [15:0] a);
        return {16{16'hA5A5, a}};
    endfunction

    // Data memory: block for the presented address, one cycle later
    always @(posedge clk) bus.accel_rd_data <= blk_of(bus.accel_addr) ^ {16{salt}};

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (bus.accel_wrt_en) begin
            if (exp_wr.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write: addr %0h data %0h", bus.accel_addr, bus.accel_wrt_data);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", 512'(bus.accel_addr), 512'(w.addr));
                chk("wr_data", 512'(bus.accel_wrt_data), 512'(w.data));
            end
            wr_seen++;
        end
        if (bus.blk_valid) begin
            if (exp_blk.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_blk_valid: data %0h", bus.blk_data);
            end else begin
                chk("blk_data", bus.blk_data, exp_blk[0]);
                if (bus.blk_ready) void'(exp_blk.pop_front());
            end
        end
        if (bus.done) begin
            if (exp_done.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: cycle %0d", cyc);
            end else begin
                int d;
                d = exp_done.pop_front();
                if (d >= 0) chk("done_cycle", 512'(cyc), 512'(d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    // Drive one doorbell store in the current cycle; returns its cycle
    task automatic doorbell(input logic [31:0] d, output int t);
        bus.cpu_wrt_en   = 1'b1;
        bus.cpu_addr     = 16'hFFF0;
        bus.cpu_wrt_data = d;
        t = cyc;
        step();
        bus.cpu_wrt_en   = 1'b0;
        bus.cpu_addr     = 16'h0000;
    endtask

    task automatic push_job(input logic [15:0] src, input logic [15:0] dst,
                            input logic [31:0] w[8], input int nwords, input int dcyc);
        exp_blk.push_back(blk_of(src));
        for (int i = 0; i < nwords; i++) exp_wr.push_back('{addr: dst + 16'(4 * i), data: w[i]});
        if (dcyc != -2) exp_done.push_back(dcyc);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 80) begin
            step();
            n++;
        end
        if (bus.busy) begin
            checks++; failures++;
            $display("FAIL %s_timeout: busy %0b expected 0", nm, bus.busy);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_accel_addr"}, 512'(bus.accel_addr), '0);
        chk({nm, "_wrt_en"},     512'(bus.accel_wrt_en), '0);
        chk({nm, "_wrt_data"},   512'(bus.accel_wrt_data), '0);
        chk({nm, "_blk_valid"},  512'(bus.blk_valid), '0);
        chk({nm, "_blk_data"},   bus.blk_data, '0);
        chk({nm, "_dig_ready"},  512'(bus.dig_ready), '0);
        chk({nm, "_busy"},       512'(bus.busy), '0);
        chk({nm, "_done"},       512'(bus.done), '0);
        chk({nm, "_err"},        512'(bus.err), '0);
    endtask

    initial begin
        int t;
        int t2;
        int base;
        int n;
        rst = 1'b1;
        bus.cpu_wrt_en   = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wrt_data = '0;
        bus.blk_ready    = 1'b1;
        bus.dig_valid    = 1'b1;
        bus.dig_data     = D1;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Basic job
        doorbell(32'h0100_0040, t);
        push_job(16'h0040, 16'h0100, W1, 8, t + 13);
        wait_cyc(t + 3);
        chk("basic_blk_valid", 512'(bus.blk_valid), 512'(1));
        wait_cyc(t + 13);
        chk("basic_busy_in_done", 512'(bus.busy), 512'(1));
        step();
        chk("basic_busy_after", 512'(bus.busy), 512'(0));

        // Backpressure: block held while memory data keeps changing
        bus.blk_ready = 1'b0;
        doorbell(32'h0200_0080, t);
        push_job(16'h0080, 16'h0200, W1, 8, t + 23);
        wait_cyc(t + 3);
        for (int i = 0; i < 10; i++) begin
            salt = 32'h1357_0000 + 32'(i);
            chk("bp_blk_valid_held", 512'(bus.blk_valid), 512'(1));
            step();
        end
        salt = '0;
        bus.blk_ready = 1'b1;
        step();
        chk("bp_blk_valid_drop", 512'(bus.blk_valid), 512'(0));
        chk("bp_dig_ready", 512'(bus.dig_ready), 512'(1));
        wait_idle("bp");

        // Doorbell while busy sets err, first job is unaffected
        bus.dig_valid = 1'b0;
        bus.dig_data  = D2;
        doorbell(32'h0400_0300, t);
        push_job(16'h0300, 16'h0400, W2, 8, -1);
        n = 0;
        while (!bus.dig_ready && n < 20) begin step(); n++; end
        chk("busy_db_wait_dig", 512'(bus.dig_ready), 512'(1));
        doorbell(32'h0500_0600, t2);
        chk("busy_db_err_set", 512'(bus.err), 512'(1));
        chk("busy_db_still_wait", 512'(bus.dig_ready), 512'(1));
        bus.dig_valid = 1'b1;
        wait_idle("busy_db");
        chk("busy_db_err_sticky", 512'(bus.err), 512'(1));
        bus.dig_data = D1;
        doorbell(32'h0800_0900, t);
        push_job(16'h0900, 16'h0800, W1, 8, t + 13);
        chk("err_cleared", 512'(bus.err), 512'(0));
        wait_idle("err_clr");

        // Back-to-back: second doorbell in the done cycle
        doorbell(32'h0A00_0B00, t);
        push_job(16'h0B00, 16'h0A00, W1, 8, t + 13);
        wait_cyc(t + 13);
        doorbell(32'h0C00_0D00, t2);
        push_job(16'h0D00, 16'h0C00, W1, 8, t2 + 13);
        chk("b2b_busy", 512'(bus.busy), 512'(1));
        chk("b2b_rd_addr", 512'(bus.accel_addr), 512'(16'h0D00));
        chk("b2b_no_err", 512'(bus.err), 512'(0));
        wait_idle("b2b");

        // Destination address wrap
        doorbell(32'hFFF8_0010, t);
        exp_blk.push_back(blk_of(16'h0010));
        for (int i = 0; i < 8; i++) exp_wr.push_back('{addr: WRAP_A[i], data: W1[i]});
        exp_done.push_back(t + 13);
        wait_idle("wrap");

        // Reset during WRITE at word 3
        base = wr_seen;
        doorbell(32'h0700_0A00, t);
        push_job(16'h0A00, 16'h0700, W1, 4, -2);
        n = 0;
        while (wr_seen < base + 4 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reached_i3", 512'(wr_seen), 512'(base + 4));
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("rst_mid_idle", 512'(bus.busy), 512'(0));
        chk("rst_mid_no_writes", 512'(wr_seen), 512'(base + 4));
        doorbell(32'h0110_0120, t);
        push_job(16'h0120, 16'h0110, W1, 8, t + 13);
        wait_idle("post_rst");
        step();

        chk("sb_writes_drained", 512'(exp_wr.size()), '0);
        chk("sb_blocks_drained", 512'(exp_blk.size()), '0);
        chk("sb_done_drained", 512'(exp_done.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
